usb_stream_sink: RTL and testbench

- Consumer and checker for the EP2 bulk OUT (host→device) byte stream leaving usb_fifo (o_ep2_rx_dval/o_ep2_rx_data); drives i_ep2_rx_rdy.
- It is the receive-side counterpart of the constant-byte IN streamer. It verifies a constant or incrementing payload, counts bytes and errors, and measures throughput per time window.
- Sits in the PHY_CLKOUT (60 MHz) domain. Outputs go to LEDs/debug.

---
 rtl/usb_stream_pkg.sv | 16 +
 rtl/usb_rate_meter.sv | 47 ++++
 rtl/usb_stream_sink.sv | 139 +++++++++++++
 tb/tb_usb_stream_sink.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_stream_pkg.sv
// Shared types and widths for the EP2 bulk OUT stream checker.
package usb_stream_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOCK = 2'd1,
    S_LOST = 2'd2
  } state_t;

  localparam logic MODE_CONST = 1'b0;
  localparam logic MODE_INCR  = 1'b1;

  localparam int BYTE_CNT_W = 32;
  localparam int ERR_CNT_W  = 16;

endpackage

// File: rtl/usb_rate_meter.sv
// Counts accepted bytes per fixed window of clock cycles and publishes the total.
module usb_rate_meter
  import usb_stream_pkg::*;
#(
  parameter int WINDOW_CYCLES = 60_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_accept,
  output logic [BYTE_CNT_W-1:0] o_rate,
  output logic                  o_rate_vld
);

  localparam logic [31:0] LAST_CYC = 32'(WINDOW_CYCLES - 1);

  logic [31:0]           cyc_cnt;
  logic [BYTE_CNT_W-1:0] win_bytes;
  logic [BYTE_CNT_W-1:0] win_next;

  // Saturating sum including the byte accepted in this cycle.
  always_comb begin
    win_next = win_bytes;
    if (i_accept && (win_bytes != '1)) win_next = win_bytes + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clear) begin
      cyc_cnt    <= '0;
      win_bytes  <= '0;
      o_rate     <= '0;
      o_rate_vld <= 1'b0;
    end else begin
      o_rate_vld <= 1'b0;
      if (cyc_cnt == LAST_CYC) begin
        cyc_cnt    <= '0;
        win_bytes  <= '0;
        o_rate     <= win_next;
        o_rate_vld <= 1'b1;
      end else begin
        cyc_cnt   <= cyc_cnt + 32'd1;
        win_bytes <= win_next;
      end
    end
  end

endmodule

// File: rtl/usb_stream_sink.sv
// EP2 bulk OUT sink: accepts bytes from usb_fifo, checks constant/incrementing payload,
// tracks lock, counts bytes and errors, and reports throughput per window.
//   state  | meaning
//   S_IDLE | no byte seen since reset/clear; first byte seeds the sequence
//   S_LOCK | pattern locked, o_locked = 1
//   S_LOST | lock dropped after LOST_TH consecutive mismatches
module usb_stream_sink
  import usb_stream_pkg::*;
#(
  parameter int WINDOW_CYCLES = 60_000_000,
  parameter int LOST_TH       = 4,
  parameter int RELOCK_TH     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_clear,
  input  logic                  i_mode,
  input  logic [7:0]            i_const,
  input  logic                  i_stall,
  input  logic                  i_rx_dval,
  input  logic [7:0]            i_rx_data,
  output logic                  o_rx_rdy,
  output logic                  o_locked,
  output logic [BYTE_CNT_W-1:0] o_byte_cnt,
  output logic [ERR_CNT_W-1:0]  o_err_cnt,
  output logic                  o_first_err_vld,
  output logic [BYTE_CNT_W-1:0] o_first_err_idx,
  output logic [7:0]            o_first_err_exp,
  output logic [7:0]            o_first_err_got,
  output logic [BYTE_CNT_W-1:0] o_rate,
  output logic                  o_rate_vld
);

  localparam logic [15:0] LOST_N   = 16'(LOST_TH);
  localparam logic [15:0] RELOCK_N = 16'(RELOCK_TH);

  state_t      state;
  logic [7:0]  exp_byte;
  logic [15:0] bad_run;
  logic [15:0] good_run;
  logic        accept;
  logic [7:0]  ref_byte;
  logic        checked;
  logic        mismatch;

  assign accept   = i_rx_dval & o_rx_rdy;
  assign ref_byte = (i_mode == MODE_INCR) ? exp_byte : i_const;
  // In incrementing mode the very first byte only seeds the sequence.
  assign checked  = (state != S_IDLE) || (i_mode == MODE_CONST);
  assign mismatch = checked && (i_rx_data != ref_byte);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rx_rdy        <= 1'b0;
      state           <= S_IDLE;
      exp_byte        <= '0;
      bad_run         <= '0;
      good_run        <= '0;
      o_locked        <= 1'b0;
      o_byte_cnt      <= '0;
      o_err_cnt       <= '0;
      o_first_err_vld <= 1'b0;
      o_first_err_idx <= '0;
      o_first_err_exp <= '0;
      o_first_err_got <= '0;
    end else begin
      o_rx_rdy <= ~i_stall;
      if (i_clear) begin
        state           <= S_IDLE;
        exp_byte        <= '0;
        bad_run         <= '0;
        good_run        <= '0;
        o_locked        <= 1'b0;
        o_byte_cnt      <= '0;
        o_err_cnt       <= '0;
        o_first_err_vld <= 1'b0;
        o_first_err_idx <= '0;
        o_first_err_exp <= '0;
        o_first_err_got <= '0;
      end else if (accept) begin
        o_byte_cnt <= o_byte_cnt + 1'b1;
        exp_byte   <= i_rx_data + 8'd1;
        if (mismatch) begin
          if (o_err_cnt != '1) o_err_cnt <= o_err_cnt + 1'b1;
          if (!o_first_err_vld) begin
            o_first_err_vld <= 1'b1;
            o_first_err_idx <= o_byte_cnt;
            o_first_err_exp <= ref_byte;
            o_first_err_got <= i_rx_data;
          end
        end
        case (state)
          S_IDLE: begin
            state    <= S_LOCK;
            o_locked <= 1'b1;
            bad_run  <= {15'd0, mismatch};
          end
          S_LOCK: begin
            if (mismatch) begin
              bad_run <= bad_run + 16'd1;
              if (bad_run + 16'd1 == LOST_N) begin
                state    <= S_LOST;
                o_locked <= 1'b0;
                good_run <= '0;
              end
            end else begin
              bad_run <= '0;
            end
          end
          S_LOST: begin
            if (mismatch) begin
              good_run <= '0;
            end else begin
              good_run <= good_run + 16'd1;
              if (good_run + 16'd1 == RELOCK_N) begin
                state    <= S_LOCK;
                o_locked <= 1'b1;
                bad_run  <= '0;
              end
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  usb_rate_meter #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_rate_meter (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (i_clear),
    .i_accept   (accept & ~i_clear),
    .o_rate     (o_rate),
    .o_rate_vld (o_rate_vld)
  );

endmodule

// File: tb/tb_usb_stream_sink.sv
// Scoreboard bench for usb_stream_sink: a negedge reference model queues expected
// results, a monitor pops them whenever the DUT byte count or rate output changes.
module tb_usb_stream_sink;

  localparam int WIN       = 100;
  localparam int LOST_TH   = 4;
  localparam int RELOCK_TH = 8;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_clear, i_mode, i_stall, i_rx_dval;
  logic [7:0]  i_const, i_rx_data;
  logic        o_rx_rdy, o_locked, o_first_err_vld, o_rate_vld;
  logic [31:0] o_byte_cnt, o_first_err_idx, o_rate;
  logic [15:0] o_err_cnt;
  logic [7:0]  o_first_err_exp, o_first_err_got;

  usb_stream_sink #(.WINDOW_CYCLES(WIN), .LOST_TH(LOST_TH), .RELOCK_TH(RELOCK_TH)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_mode(i_mode),
    .i_const(i_const), .i_stall(i_stall), .i_rx_dval(i_rx_dval), .i_rx_data(i_rx_data),
    .o_rx_rdy(o_rx_rdy), .o_locked(o_locked), .o_byte_cnt(o_byte_cnt),
    .o_err_cnt(o_err_cnt), .o_first_err_vld(o_first_err_vld),
    .o_first_err_idx(o_first_err_idx), .o_first_err_exp(o_first_err_exp),
    .o_first_err_got(o_first_err_got), .o_rate(o_rate), .o_rate_vld(o_rate_vld)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic [31:0] cnt;
    logic [15:0] err;
    logic        locked;
    logic        fv;
    logic [31:0] fidx;
    logic [7:0]  fexp;
    logic [7:0]  fgot;
  } rec_t;

  rec_t        exp_q[$];
  logic [31:0] rate_q[$];

  // ---------------- reference model ----------------
  logic [31:0] m_cnt = 0;
  int          m_err = 0;
  bit          m_started = 0, m_locked = 0, m_fv = 0;
  int          m_bad = 0, m_good = 0;
  logic [7:0]  m_next = 0, m_fexp = 0, m_fgot = 0;
  logic [31:0] m_fidx = 0;
  bit          m_rdy = 0, m_acc = 0;
  int          m_wcyc = 0;
  longint      m_wbytes = 0;

  task automatic push_rec();
    rec_t r;
    r.cnt = m_cnt; r.err = 16'(m_err); r.locked = m_locked; r.fv = m_fv;
    r.fidx = m_fidx; r.fexp = m_fexp; r.fgot = m_fgot;
    exp_q.push_back(r);
  endtask

  always @(negedge i_clk) begin
    logic [7:0] want;
    bit         is_bad, acc;
    if (i_rst_n === 1'b1) chk("rx_rdy", {31'd0, o_rx_rdy}, {31'd0, m_rdy});
    acc   = i_rx_dval && m_rdy && i_rst_n && !i_clear;
    m_acc = acc;
    if (!i_rst_n || i_clear) begin
      if (m_cnt != 0) begin
        m_cnt = 0; m_err = 0; m_locked = 0; m_fv = 0; m_fidx = 0; m_fexp = 0; m_fgot = 0;
        push_rec();
      end
      m_started = 0; m_locked = 0; m_bad = 0; m_good = 0; m_next = 0;
      m_wcyc = 0; m_wbytes = 0;
    end else begin
      if (acc) begin
        want   = i_mode ? m_next : i_const;
        is_bad = (m_started || !i_mode) && (i_rx_data != want);
        if (is_bad) begin
          if (m_err < 65535) m_err++;
          if (!m_fv) begin m_fv = 1; m_fidx = m_cnt; m_fexp = want; m_fgot = i_rx_data; end
        end
        m_cnt  = m_cnt + 1;
        m_next = i_rx_data + 8'd1;
        if (!m_started) begin
          m_started = 1; m_locked = 1; m_bad = is_bad ? 1 : 0;
        end else if (m_locked) begin
          if (is_bad) begin
            m_bad++;
            if (m_bad == LOST_TH) begin m_locked = 0; m_good = 0; end
          end else m_bad = 0;
        end else begin
          if (is_bad) m_good = 0;
          else begin
            m_good++;
            if (m_good == RELOCK_TH) begin m_locked = 1; m_bad = 0; end
          end
        end
        push_rec();
      end
      m_wbytes = m_wbytes + (acc ? 1 : 0);
      if (m_wbytes > 64'hFFFF_FFFF) m_wbytes = 64'hFFFF_FFFF;
      if (m_wcyc == WIN - 1) begin
        rate_q.push_back(32'(m_wbytes));
        m_wbytes = 0; m_wcyc = 0;
      end else m_wcyc++;
    end
    m_rdy = i_rst_n ? !i_stall : 1'b0;
  end

  // ---------------- monitor ----------------
  logic [31:0] mon_prev = 0;
  always begin
    rec_t r;
    @(posedge i_clk); #1;
    if (o_byte_cnt !== mon_prev) begin
      mon_prev = o_byte_cnt;
      if (exp_q.size() == 0) chk("unexpected_update", o_byte_cnt, 32'hFFFF_FFFF);
      else begin
        r = exp_q.pop_front();
        chk("byte_cnt", o_byte_cnt, r.cnt);
        chk("err_cnt", {16'd0, o_err_cnt}, {16'd0, r.err});
        chk("locked", {31'd0, o_locked}, {31'd0, r.locked});
        chk("fe_vld", {31'd0, o_first_err_vld}, {31'd0, r.fv});
        chk("fe_idx", o_first_err_idx, r.fidx);
        chk("fe_exp", {24'd0, o_first_err_exp}, {24'd0, r.fexp});
        chk("fe_got", {24'd0, o_first_err_got}, {24'd0, r.fgot});
      end
    end
    if (o_rate_vld === 1'b1) begin
      if (rate_q.size() == 0) chk("unexpected_rate", o_rate, 32'hFFFF_FFFF);
      else chk("rate", o_rate, rate_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  int stall_pct = 0;

  task automatic cyc(input int n);
    repeat (n) begin @(posedge i_clk); #2; end
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    i_rx_dval = 1'b1; i_rx_data = d;
    forever begin
      @(posedge i_clk); #2;
      i_stall = ($urandom_range(99) < stall_pct);
      if (m_acc) break;
      n++;
      if (n > 200) begin chk("send_timeout", 32'(n), 32'd0); break; end
    end
    i_rx_dval = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1; cyc(1); i_clear = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [31:0] base;
    int pulses, lastc;
    logic [7:0] seq3 [6];
    seq3 = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h10, 8'h11};
    i_rst_n = 0; i_clear = 0; i_mode = 0; i_const = 8'hEF; i_stall = 0;
    i_rx_dval = 1; i_rx_data = 8'hAA;
    @(posedge i_clk); #2; cyc(2);
    chk("rst_rdy", {31'd0, o_rx_rdy}, 0);
    chk("rst_cnt", o_byte_cnt, 0);
    chk("rst_err", {16'd0, o_err_cnt}, 0);
    chk("rst_locked", {31'd0, o_locked}, 0);
    chk("rst_rate_vld", {31'd0, o_rate_vld}, 0);
    i_rst_n = 1; i_rx_dval = 0;
    cyc(1);
    chk("rdy_after_rst", {31'd0, o_rx_rdy}, 1);

    // constant pattern, 1000 bytes with random backpressure
    stall_pct = 25;
    for (int i = 0; i < 1000; i++) send_byte(8'hEF);
    chk("p1_cnt", o_byte_cnt, 1000);
    chk("p1_err", {16'd0, o_err_cnt}, 0);
    chk("p1_locked", {31'd0, o_locked}, 1);
    chk("p1_fe_vld", {31'd0, o_first_err_vld}, 0);

    // incrementing with a single jump
    do_clear(); i_mode = 1;
    for (int i = 0; i < 6; i++) send_byte(seq3[i]);
    chk("p2_err", {16'd0, o_err_cnt}, 1);
    chk("p2_fe_vld", {31'd0, o_first_err_vld}, 1);
    chk("p2_fe_idx", o_first_err_idx, 4);
    chk("p2_fe_exp", {24'd0, o_first_err_exp}, 32'h02);
    chk("p2_fe_got", {24'd0, o_first_err_got}, 32'h10);
    chk("p2_locked", {31'd0, o_locked}, 1);

    // lose and regain lock
    do_clear();
    send_byte(8'($urandom));
    for (int i = 0; i < 4; i++) begin
      d = m_next + 8'($urandom_range(1, 255));
      send_byte(d);
      if (i == 2) chk("p3_locked_th_minus1", {31'd0, o_locked}, 1);
    end
    chk("p3_err", {16'd0, o_err_cnt}, 4);
    chk("p3_lost", {31'd0, o_locked}, 0);
    for (int i = 0; i < 8; i++) begin
      send_byte(m_next);
      if (i == 6) chk("p3_relock_minus1", {31'd0, o_locked}, 0);
    end
    chk("p3_relocked", {31'd0, o_locked}, 1);
    chk("p3_err_hold", {16'd0, o_err_cnt}, 4);

    // randomized mixed traffic, mode/const changes between bytes
    stall_pct = 30;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(15) == 0) i_mode = ~i_mode;
      if ($urandom_range(31) == 0) i_const = 8'($urandom);
      if ($urandom_range(99) < 70) d = i_mode ? m_next : i_const;
      else d = 8'($urandom);
      send_byte(d);
    end

    // throughput: dval held, stall toggles every 10 cycles
    i_stall = 1; i_mode = 0; i_const = 8'hEF;
    do_clear();
    i_rx_dval = 1; i_rx_data = 8'hEF;
    pulses = 0; lastc = 0;
    for (int c = 0; c < 305; c++) begin
      @(posedge i_clk); #2;
      i_stall = ((c / 10) % 2) != 0;
      if (o_rate_vld) begin
        pulses++;
        chk("rate_range", {31'd0, (o_rate >= 49 && o_rate <= 51)}, 1);
        if (pulses > 1) chk("rate_period", 32'(c - lastc), 32'(WIN));
        lastc = c;
      end
    end
    chk("rate_pulses", 32'(pulses), 3);
    i_rx_dval = 0; i_stall = 0;

    // clear colliding with an accept
    stall_pct = 0;
    cyc(2);
    do_clear();
    for (int i = 0; i < 20; i++) send_byte((i == 10) ? 8'h00 : 8'hEF);
    i_rx_dval = 1; i_rx_data = 8'hEF; i_clear = 1;
    cyc(1);
    i_clear = 0; i_rx_dval = 0;
    chk("clr_cnt", o_byte_cnt, 0);
    chk("clr_err", {16'd0, o_err_cnt}, 0);
    chk("clr_locked", {31'd0, o_locked}, 0);
    chk("clr_fe_vld", {31'd0, o_first_err_vld}, 0);
    chk("clr_rate", o_rate, 0);
    i_mode = 1;
    send_byte(8'h40); send_byte(8'h41);
    chk("reseed_cnt", o_byte_cnt, 2);
    chk("reseed_err", {16'd0, o_err_cnt}, 0);
    chk("reseed_locked", {31'd0, o_locked}, 1);

    // error counter saturation
    do_clear();
    send_byte(8'h00);
    while (m_err < 16'hFFFE) send_byte(8'h33);
    chk("sat_pre", {16'd0, o_err_cnt}, 32'hFFFE);
    base = o_byte_cnt;
    for (int i = 0; i < 3; i++) send_byte(8'h33);
    chk("sat_err", {16'd0, o_err_cnt}, 32'hFFFF);
    chk("sat_cnt", o_byte_cnt, base + 3);

    // reset with dval high
    i_rx_dval = 1; i_rx_data = 8'h34; i_rst_n = 0;
    cyc(1);
    chk("rst_dval_rdy", {31'd0, o_rx_rdy}, 0);
    chk("rst_dval_cnt", o_byte_cnt, 0);
    i_rst_n = 1; i_rx_dval = 0;
    cyc(3);
    chk("exp_q_empty", 32'(exp_q.size()), 0);
    chk("rate_q_empty", 32'(rate_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
